// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and line levels.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Receiver-side bus: serial line and freeze control in, word and status strobes out.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             Hold;
  logic             D;
  logic [WIDTH-1:0] Q;
  logic             Valid;
  logic             FrameErr;
  logic             ParErr;

  modport master (
    output Hold, D,
    input  Q, Valid, FrameErr, ParErr
  );

  modport slave (
    input  Hold, D,
    output Q, Valid, FrameErr, ParErr
  );
endinterface

// File: rtl/serial_frame_rx_bit_counter.sv
// Saturating up-counter for the data phase; stops at WIDTH instead of wrapping.
module bit_counter
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Clr,
  input  logic                       En,
  output logic [$clog2(WIDTH+1)-1:0] Count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MAX = CW'(WIDTH);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Clr) begin
      count_d = '0;
    end else if (En && (count_q != MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits LSB first, optional even parity, stop.
// Define PARITY_EN to expect an even-parity bit between the data and stop bits.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               Clk,
  input logic               Rst_n,
  serial_frame_rx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             parbad_q, parbad_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [CW-1:0]    cnt;
  logic             cnt_clr, cnt_en;
`ifdef PARITY_EN
  logic             perr_q, perr_d;
`endif

  // Counter is only stepped from the FSM, so Hold freezes it as well.
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Clr   (cnt_clr),
    .En    (cnt_en),
    .Count (cnt)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    q_d      = q_q;
    parbad_d = parbad_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef PARITY_EN
    perr_d   = 1'b0;
`endif
    if (!bus.Hold) begin
      case (state_q)
        IDLE: begin
          if (bus.D == START_BIT) begin
            state_d  = DATA;
            cnt_clr  = 1'b1;
            parbad_d = 1'b0;
          end
        end
        DATA: begin
          shift_d            = shift_q >> 1;
          shift_d[WIDTH-1]   = bus.D;
          cnt_en             = 1'b1;
          if (cnt == LAST) begin
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end
        PAR: begin
`ifdef PARITY_EN
          // Even parity: data ones plus the parity bit must be even.
          parbad_d = (^shift_q) ^ bus.D;
          state_d  = STOP;
`else
          state_d  = IDLE;
`endif
        end
        STOP: begin
          state_d = IDLE;
          if ((bus.D == STOP_BIT) && !parbad_q) begin
            q_d     = shift_q;
            valid_d = 1'b1;
          end
          ferr_d = (bus.D != STOP_BIT);
`ifdef PARITY_EN
          perr_d = parbad_q;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      q_q      <= '0;
      parbad_q <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      q_q      <= q_d;
      parbad_q <= parbad_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign bus.ParErr = perr_q;
`else
  assign bus.ParErr = 1'b0;
`endif

  assign bus.Q        = q_q;
  assign bus.Valid    = valid_q;
  assign bus.FrameErr = ferr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised and directed bench for serial_frame_rx (WIDTH=8), honours PARITY_EN.
module tb_serial_frame_rx;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] q_model;

  serial_frame_rx_if #(.WIDTH(W)) bus ();

  serial_frame_rx #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input logic d, input logic h);
    bus.D    = d;
    bus.Hold = h;
    @(posedge Clk);
    #1;
  endtask

  // Drives one frame; reports the edge (start edge = 1) at which each strobe appeared
  // on the final bit, and how many strobes or Q changes showed up anywhere else.
  task automatic send_frame(input logic [W-1:0] data, input logic stop, input logic par_flip,
                            input int hold_at, input int hold_len,
                            output int vld_edge, output int fe_edge, output int pe_edge,
                            output int stray);
    logic bq[$];
    logic [W-1:0] q0;
    int e;
    bq.delete();
    bq.push_back(1'b0);
    for (int i = 0; i < W; i++) bq.push_back(data[i]);
`ifdef PARITY_EN
    bq.push_back((^data) ^ par_flip);
`endif
    bq.push_back(stop);
    e = 0; vld_edge = 0; fe_edge = 0; pe_edge = 0; stray = 0;
    for (int k = 0; k < bq.size(); k++) begin
      if (k == hold_at) begin
        for (int j = 0; j < hold_len; j++) begin
          q0 = bus.Q;
          tick(1'($urandom % 2), 1'b1);
          e++;
          if (bus.Valid || bus.FrameErr || bus.ParErr || bus.Q !== q0) stray++;
        end
      end
      q0 = bus.Q;
      tick(bq[k], 1'b0);
      e++;
      if (k != bq.size() - 1) begin
        if (bus.Valid || bus.FrameErr || bus.ParErr || bus.Q !== q0) stray++;
      end else begin
        if (bus.Valid)    vld_edge = e;
        if (bus.FrameErr) fe_edge  = e;
        if (bus.ParErr)   pe_edge  = e;
      end
    end
  endtask

  task automatic test_reset();
    int v, f, p, s;
    tick(1'b1, 1'b0);
    tests++;
    if ({bus.Q, bus.Valid, bus.FrameErr, bus.ParErr} !== '0) begin
      fails++;
      $display("FAIL reset_state: got Q=%h V=%b FE=%b PE=%b, want all 0", bus.Q, bus.Valid, bus.FrameErr, bus.ParErr);
    end
    Rst_n = 1'b1;
    tick(1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (bus.Q !== 8'h5A || v != NB) begin
      fails++;
      $display("FAIL pre_reset_frame: got Q=%h vld_edge=%0d, want Q=5a vld_edge=%0d", bus.Q, v, NB);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.Q, bus.Valid, bus.FrameErr, bus.ParErr} !== '0) begin
      fails++;
      $display("FAIL reset_midframe: got Q=%h V=%b FE=%b, want all 0", bus.Q, bus.Valid, bus.FrameErr);
    end
    s = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'($urandom % 2), 1'b0);
      if (bus.Q !== '0 || bus.Valid || bus.FrameErr || bus.ParErr) s++;
    end
    tests++;
    if (s != 0) begin
      fails++;
      $display("FAIL reset_hold: got %0d bad cycles, want 0", s);
    end
    Rst_n = 1'b1;
    tick(1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (bus.Q !== 8'hA5 || v != NB || f != 0 || s != 0) begin
      fails++;
      $display("FAIL reset_recover: got Q=%h vld_edge=%0d fe=%0d stray=%0d, want Q=a5 vld_edge=%0d", bus.Q, v, f, s, NB);
    end
    tick(1'b1, 1'b0);
    tests++;
    if (bus.Valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_one_cycle: got Valid=%b, want 0", bus.Valid);
    end
    q_model = 8'hA5;
  endtask

  task automatic test_latency();
    int v, f, p, s;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    tests++;
    if (bus.Valid || bus.FrameErr || bus.Q !== q_model) begin
      fails++;
      $display("FAIL idle_quiet: got V=%b FE=%b Q=%h, want 0 0 %h", bus.Valid, bus.FrameErr, bus.Q, q_model);
    end
    send_frame(8'hA5, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (v != NB || bus.Q !== 8'hA5 || s != 0) begin
      fails++;
      $display("FAIL latency: got vld_edge=%0d Q=%h stray=%0d, want %0d a5 0", v, bus.Q, s, NB);
    end
    q_model = 8'hA5;
    tick(1'b1, 1'b0);
  endtask

  task automatic test_frame_err();
    int v, f, p, s;
    send_frame(8'h3C, 1'b0, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (f != NB || v != 0 || p != 0 || bus.Q !== 8'hA5 || s != 0) begin
      fails++;
      $display("FAIL frame_err: got fe=%0d v=%0d pe=%0d Q=%h stray=%0d, want fe=%0d v=0 pe=0 Q=a5", f, v, p, bus.Q, s, NB);
    end
    tick(1'b1, 1'b0);
    tests++;
    if (bus.FrameErr !== 1'b0) begin
      fails++;
      $display("FAIL frame_err_one_cycle: got FrameErr=%b, want 0", bus.FrameErr);
    end
  endtask

  task automatic test_hold();
    int v, f, p, s;
    send_frame(8'hFF, 1'b1, 1'b0, 4, 4, v, f, p, s);
    tests++;
    if (v != NB + 4 || bus.Q !== 8'hFF || s != 0) begin
      fails++;
      $display("FAIL hold: got vld_edge=%0d Q=%h stray=%0d, want %0d ff 0", v, bus.Q, s, NB + 4);
    end
    q_model = 8'hFF;
    tick(1'b1, 1'b0);
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int v, f, p, s;
    send_frame(8'h01, 1'b1, 1'b1, -1, 0, v, f, p, s);
    tests++;
    if (p != NB || v != 0 || f != 0 || bus.Q !== q_model) begin
      fails++;
      $display("FAIL parity_bad: got pe=%0d v=%0d fe=%0d Q=%h, want pe=%0d v=0 fe=0 Q=%h", p, v, f, bus.Q, NB, q_model);
    end
    tick(1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (v != NB || p != 0 || bus.Q !== 8'h01) begin
      fails++;
      $display("FAIL parity_good: got v=%0d pe=%0d Q=%h, want v=%0d pe=0 Q=01", v, p, bus.Q, NB);
    end
    q_model = 8'h01;
    tick(1'b1, 1'b0);
    send_frame(8'h77, 1'b0, 1'b1, -1, 0, v, f, p, s);
    tests++;
    if (v != 0 || p != NB || f != NB || bus.Q !== 8'h01) begin
      fails++;
      $display("FAIL both_errs: got v=%0d pe=%0d fe=%0d Q=%h, want v=0 pe=fe=%0d Q=01", v, p, f, bus.Q, NB);
    end
    tick(1'b1, 1'b0);
  endtask
`endif

  task automatic test_back_to_back();
    int v, f, p, s;
    send_frame(8'h12, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (v != NB || bus.Q !== 8'h12) begin
      fails++;
      $display("FAIL b2b_first: got v=%0d Q=%h, want %0d 12", v, bus.Q, NB);
    end
    tick(1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, -1, 0, v, f, p, s);
    tests++;
    if (v != NB || bus.Q !== 8'h34 || s != 0) begin
      fails++;
      $display("FAIL b2b_second: got v=%0d Q=%h stray=%0d, want %0d 34 0", v, bus.Q, s, NB);
    end
    q_model = 8'h34;
    tick(1'b1, 1'b0);
  endtask

  task automatic test_random();
    int v, f, p, s, ha, hl, gap;
    int exp_v, exp_f, exp_p;
    logic [W-1:0] data;
    logic stop, flip;
    for (int n = 0; n < 30; n++) begin
      data = W'($urandom);
      stop = ($urandom % 4) != 0;
`ifdef PARITY_EN
      flip = ($urandom % 4) == 0;
`else
      flip = 1'b0;
`endif
      ha = ($urandom % 3 == 0) ? int'($urandom % NB) : -1;
      hl = (ha >= 0) ? int'($urandom_range(1, 5)) : 0;
      send_frame(data, stop, flip, ha, hl, v, f, p, s);
      exp_v = (stop && !flip) ? NB + hl : 0;
      exp_f = stop ? 0 : NB + hl;
      exp_p = flip ? NB + hl : 0;
      if (stop && !flip) q_model = data;
      tests++;
      if (v != exp_v || f != exp_f || p != exp_p || bus.Q !== q_model || s != 0) begin
        fails++;
        $display("FAIL random_%0d: got v=%0d fe=%0d pe=%0d Q=%h stray=%0d, want v=%0d fe=%0d pe=%0d Q=%h stray=0",
                 n, v, f, p, bus.Q, s, exp_v, exp_f, exp_p, q_model);
      end
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) tick(1'b1, 1'b0);
    end
  endtask

  initial begin
    bus.D    = 1'b1;
    bus.Hold = 1'b0;
    Rst_n    = 1'b0;
    q_model  = '0;
    test_reset();
    test_latency();
    test_frame_err();
    test_hold();
`ifdef PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
